// File: rtl/msrv32_wb_reg_file_unit_if.sv
// Write-back / register-file bus: write-back port, two read ports and status.
// The pipeline side takes the master modport and the register file takes the slave modport.
interface msrv32_wb_reg_file_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] wb_mux_out_in;
  logic [4:0]      rd_addr_in;
  logic            wr_en_in;
  logic            flush_in;
  logic [4:0]      rs_1_addr_in;
  logic [4:0]      rs_2_addr_in;
  logic [XLEN-1:0] rs_1_out;
  logic [XLEN-1:0] rs_2_out;
  logic            rf_ready_out;
  logic            wr_ack_out;

  modport master (
    output wb_mux_out_in, rd_addr_in, wr_en_in, flush_in, rs_1_addr_in, rs_2_addr_in,
    input  rs_1_out, rs_2_out, rf_ready_out, wr_ack_out
  );

  modport slave (
    input  wb_mux_out_in, rd_addr_in, wr_en_in, flush_in, rs_1_addr_in, rs_2_addr_in,
    output rs_1_out, rs_2_out, rf_ready_out, wr_ack_out
  );
endinterface

// File: rtl/msrv32_wb_reg_file_unit.sv
// RV32 write-back register file: 32 x XLEN unreset array, self-clearing INIT, registered reads.
// Define MSRV32_RF_BYPASS_EN to forward a same-edge committing write to matching read ports.
module msrv32_wb_reg_file_unit #(
  parameter int XLEN = 32
) (
  input logic                      ms_riscv32_mp_clk_in,
  input logic                      ms_riscv32_mp_rst_n_in,
  msrv32_wb_reg_file_unit_if.slave rf_if
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]      state_p0;
  logic [4:0]      init_cnt_p0;
  logic            run_p0;
  logic            commit_p0;
  logic [XLEN-1:0] reg_array [0:31];

  logic [XLEN-1:0] rs_1_p1;
  logic [XLEN-1:0] rs_2_p1;
  logic            rf_ready_p1;
  logic            vld_p1;

  assign run_p0    = (state_p0 == ST_RUN);
  assign commit_p0 = run_p0 && rf_if.wr_en_in && !rf_if.flush_in && (rf_if.rd_addr_in != 5'd0);

`ifdef MSRV32_RF_BYPASS_EN
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    if (!run_p0 || addr == 5'd0)
      read_port = '0;
    else if (commit_p0 && rf_if.rd_addr_in == addr)
      read_port = rf_if.wb_mux_out_in;
    else
      read_port = reg_array[addr];
  endfunction
`else
  // The array write lands on the same edge, so this returns the pre-write value.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    if (!run_p0 || addr == 5'd0)
      read_port = '0;
    else
      read_port = reg_array[addr];
  endfunction
`endif

  // Stage p0 -> p1: control state, write acknowledge and registered read data
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_p0    <= ST_INIT;
      init_cnt_p0 <= 5'd0;
      rf_ready_p1 <= 1'b0;
      vld_p1      <= 1'b0;
      rs_1_p1     <= '0;
      rs_2_p1     <= '0;
    end else begin
      if (!run_p0) begin
        init_cnt_p0 <= init_cnt_p0 + 5'd1;
        if (init_cnt_p0 == 5'd31) begin
          state_p0    <= ST_RUN;
          rf_ready_p1 <= 1'b1;
        end
      end
      vld_p1  <= commit_p0;
      rs_1_p1 <= read_port(rf_if.rs_1_addr_in);
      rs_2_p1 <= read_port(rf_if.rs_2_addr_in);
    end
  end

  // Storage has no reset so it can map onto distributed RAM; INIT sweeps it to zero.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!run_p0)
      reg_array[init_cnt_p0] <= '0;
    else if (commit_p0)
      reg_array[rf_if.rd_addr_in] <= rf_if.wb_mux_out_in;
  end

  assign rf_if.rs_1_out     = rs_1_p1;
  assign rf_if.rs_2_out     = rs_2_p1;
  assign rf_if.rf_ready_out = rf_ready_p1;
  assign rf_if.wr_ack_out   = vld_p1;

endmodule

// File: doc/msrv32_wb_reg_file_unit.md
MSRV32_WB_REG_FILE_UNIT -- requirements
Module: msrv32_wb_reg_file_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of write-back and read ports.
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_n_in, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port wb_mux_out_in, input, XLEN, write-back data from the write-back mux.
REQ-005 SHALL have port rd_addr_in, input, 5, destination register index.
REQ-006 SHALL have port wr_en_in, input, 1, write request qualifier.
REQ-007 SHALL have port flush_in, input, 1, kill of the current write.
REQ-008 SHALL have ports rs_1_addr_in and rs_2_addr_in, input, 5 each, source register indices.
REQ-009 SHALL have ports rs_1_out and rs_2_out, output, XLEN each, registered read data.
REQ-010 SHALL have port rf_ready_out, output, 1, high when the array is initialised and writes are accepted.
REQ-011 SHALL have port wr_ack_out, output, 1, registered one-cycle pulse per committed write.

Function
REQ-012 SHALL hold 32 x XLEN registers in a storage array without reset, so it maps to inferred RAM/LUT storage.
REQ-013 SHALL implement FSM states INIT and RUN; INIT clears the array, RUN serves normal traffic.
REQ-014 SHALL, in INIT, write zero to entry init_cnt each cycle (5-bit counter from 0), increment init_cnt, and enter RUN on the edge that clears entry 31: 32 clear cycles.
REQ-015 SHALL drive rf_ready_out low in INIT, high in RUN, registered from state.
REQ-016 SHALL, in INIT, silently drop wr_en_in requests (no write, no wr_ack_out) and return zero on both read ports.
REQ-017 SHALL, in RUN, commit write when wr_en_in=1, flush_in=0, rd_addr_in!=0; wr_ack_out=1 the following cycle only.
REQ-018 SHALL never write entry 0; a read of index 0 SHALL return zero regardless of array contents or bypass.
REQ-019 SHALL register reads: rs_n_out in cycle N+1 reflects rs_n_addr_in sampled at edge N (1-cycle latency), both ports independent.
REQ-020 SHALL, when rs_1_addr_in equals rs_2_addr_in, return identical data on both ports.
REQ-021 SHALL handle same-edge write/read to same nonzero index per REQ-026/REQ-027.
REQ-022 SHALL treat flush_in with priority over wr_en_in; flushed writes produce no ack and no bypass.

Reset
REQ-023 SHALL, on ms_riscv32_mp_rst_n_in low, immediately force state=INIT, init_cnt=0, rs_1_out=0, rs_2_out=0, rf_ready_out=0, wr_ack_out=0.
REQ-024 SHALL, on reset asserted mid-RUN or mid-INIT, abandon current operation and restart the full 32-cycle INIT after release; array contents are undefined until cleared.
REQ-025 SHALL begin INIT clearing on the first rising edge with reset deasserted.

Configuration
REQ-026 SHALL, with MSRV32_RF_BYPASS_EN defined, forward wb_mux_out_in to a read port whose address matches a same-edge committing write (write-through, new data in cycle N+1).
REQ-027 SHALL, without MSRV32_RF_BYPASS_EN, return the pre-write array value for that same-edge case; the new value appears on reads sampled from the next edge onward.

Verification
REQ-028 SHALL cover: reset low 3 cycles then release -> rf_ready_out low for exactly 32 edges, high after; all 32 reads return 0x00000000.
REQ-029 SHALL cover: RUN, write x5=0x12345678, next cycle read rs_1_addr=5 -> wr_ack_out pulse 1 cycle, rs_1_out=0x12345678 one cycle after address.
REQ-030 SHALL cover: write x0=0xDEADBEEF with wr_en_in=1 -> no ack, read x0 returns 0x00000000.
REQ-031 SHALL cover: write x7=0xFEEDFACE with flush_in=1 -> no ack, x7 keeps prior value 0xBABECAFE.
REQ-032 SHALL cover: same-edge write x9=0x87654321 and read rs_2_addr=9 (old 0xABCDEF01) -> rs_2_out=0x87654321 with MSRV32_RF_BYPASS_EN, 0xABCDEF01 without.
REQ-033 SHALL cover: reset pulse during INIT at init_cnt=10 and during RUN after writes -> outputs zero at once, full 32-cycle INIT repeats, prior values read as zero.
